instr_loader: RTL
=================

INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter: TAM, default 32, instruction word width in bits.
REQ-002 Parameter: DEPTH, default 2048, number of instruction memory words.
REQ-003 Parameter: AW, default 11, write-address width; the SHALL rule is DEPTH = 2^AW.
REQ-004 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port: rst_n  input  1  reset; asynchronous, active-low.
REQ-006 Port: start  input  1  one-cycle request to begin a program load.
REQ-007 Port: in_byte  input  8  program byte stream, MSB-first within each word.
REQ-008 Port: in_valid  input  1  in_byte is valid.
REQ-009 Port: in_ready  output  1  loader accepts a byte this cycle.
REQ-010 Port: wr_en  output  1  write strobe to instruction memory.
REQ-011 Port: wr_addr  output  AW  instruction memory word address.
REQ-012 Port: wr_data  output  TAM  instruction word to write.
REQ-013 Port: busy  output  1  high in LOAD and WRITE states.
REQ-014 Port: done  output  1  load finished; held until next start.
REQ-015 Port: overflow  output  1  memory filled before the end marker arrived.
REQ-016 Port: word_count  output  AW+1  number of words written in the current or last load.

Function
REQ-017 The block SHALL implement the states IDLE, LOAD, WRITE and DONE, encoded in a registered state machine.
REQ-018 A byte handshake SHALL occur only on a rising edge where in_valid=1 and in_ready=1.
REQ-019 in_ready SHALL be 1 only in LOAD, and SHALL be a function of state only.
REQ-020 IDLE: start=1 SHALL go to LOAD, clear wr_addr, the byte counter, word_count, done and overflow.
REQ-021 LOAD: each handshake SHALL shift the word register left 8 and insert in_byte at [7:0]; the byte counter SHALL count 0..3.
REQ-022 The 4th handshake SHALL go to WRITE; no byte SHALL be accepted in WRITE.
REQ-023 WRITE: wr_en=1 for exactly one cycle, with wr_data = the assembled word and wr_addr = the current address.
REQ-024 The byte counter SHALL reset to 0 in WRITE; word_count SHALL increment by 1 on leaving WRITE.
REQ-025 Leaving WRITE with wr_data = 32'hFFFF_FFFF (end marker) SHALL go to DONE; the marker itself SHALL be written.
REQ-026 Otherwise, leaving WRITE with wr_addr = DEPTH-1 SHALL go to DONE with overflow=1.
REQ-027 Otherwise, leaving WRITE SHALL go to LOAD with wr_addr+1.
REQ-028 Marker at address DEPTH-1 SHALL give done=1, overflow=0; the marker takes priority over overflow.
REQ-029 DONE: done=1, in_ready=0; start=1 SHALL restart exactly as from IDLE.
REQ-030 start SHALL be ignored in LOAD and WRITE.
REQ-031 A partial word (fewer than 4 bytes) SHALL never be written.
REQ-032 wr_addr SHALL never wrap during a load.
REQ-033 wr_data and wr_addr SHALL be don't-care when wr_en=0, but SHALL hold the last-written values.
REQ-034 Latency: wr_en SHALL rise on the cycle immediately after the 4th byte handshake.

Reset
REQ-035 rst_n=0 SHALL immediately force: state=IDLE, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, overflow=0, word_count=0, and clear the byte counter.
REQ-036 Reset asserted mid-load SHALL discard any partial word and SHALL issue no write.
REQ-037 After release, the block SHALL wait in IDLE for start.

Verification
REQ-038 start; send bytes 00 23 20 21, then FF FF FF FF -> writes 0x00232021 at addr 0 and 0xFFFFFFFF at addr 1; then done=1, overflow=0, word_count=2.
REQ-039 in_valid toggling every other cycle during a word -> the same words are written; wr_en never asserts before the 4th accepted byte.
REQ-040 Stream 2048 non-marker words -> last write at addr 2047; then done=1, overflow=1, word_count=2048, in_ready=0.
REQ-041 2047 words followed by the marker -> marker written at addr 2047; done=1, overflow=0.
REQ-042 rst_n pulsed low after 2 bytes of a word -> no wr_en; all outputs at reset values; a new start loads from addr 0.
REQ-043 start pulsed during LOAD, and start pulsed in DONE -> the first is ignored; the second clears done and reloads from addr 0.

Source files
------------

// File: rtl/instr_loader.sv
// Instruction loader: assembles an MSB-first byte stream into TAM-bit words
// and writes them to consecutive instruction-memory addresses until an
// all-ones end marker is written or the memory is full.
module instr_loader #(
    parameter int TAM   = 32,    // instruction word width, a multiple of 8
    parameter int DEPTH = 2048,  // instruction memory words, must equal 2**AW
    parameter int AW    = 11     // write-address width
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [7:0]      in_byte,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            wr_en,
    output logic [AW-1:0]   wr_addr,
    output logic [TAM-1:0]  wr_data,
    output logic            busy,
    output logic            done,
    output logic            overflow,
    output logic [AW:0]     word_count
);

    // Bytes per word and the width of the counter that walks through them.
    localparam int BPW = TAM / 8;
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

    localparam logic [CW-1:0] LAST_BYTE = CW'(BPW - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW:0]   COUNT_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]     state_q,      state_d;
    logic [TAM-1:0] word_q,       word_d;
    logic [CW-1:0]  byte_cnt_q,   byte_cnt_d;
    logic [AW-1:0]  wr_addr_q,    wr_addr_d;
    logic [TAM-1:0] wr_data_q,    wr_data_d;
    logic [AW:0]    word_count_q, word_count_d;
    logic           done_q,       done_d;
    logic           overflow_q,   overflow_d;

    logic           accept;
    logic [TAM-1:0] word_shifted;
    logic [BPW-1:0] byte_all_ones;
    logic           is_marker;

    // The end marker is recognised lane by lane; every byte must be 8'hFF.
    genvar gi;
    generate
        for (gi = 0; gi < BPW; gi++) begin : g_marker
            assign byte_all_ones[gi] = &wr_data_q[gi*8 +: 8];
        end
    endgenerate

    assign is_marker = &byte_all_ones;

    // Ready is a pure function of state so it never depends on in_valid.
    assign accept       = in_valid && (state_q == S_LOAD);
    assign word_shifted = {word_q[TAM-9:0], in_byte};

    // Next-state and datapath updates for the load state machine.
    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        byte_cnt_d   = byte_cnt_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        word_count_d = word_count_q;
        done_d       = done_q;
        overflow_d   = overflow_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                // A restart from DONE behaves exactly like a start from IDLE.
                if (start) begin
                    state_d      = S_LOAD;
                    word_d       = '0;
                    byte_cnt_d   = '0;
                    wr_addr_d    = '0;
                    word_count_d = '0;
                    done_d       = 1'b0;
                    overflow_d   = 1'b0;
                end
            end

            S_LOAD: begin
                // start is deliberately ignored here; only bytes matter.
                if (accept) begin
                    word_d = word_shifted;
                    if (byte_cnt_q == LAST_BYTE) begin
                        // Capture the full word separately so wr_data keeps the
                        // last-written value while the next word assembles.
                        state_d   = S_WRITE;
                        wr_data_d = word_shifted;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end

            S_WRITE: begin
                byte_cnt_d   = '0;
                word_count_d = word_count_q + COUNT_ONE;
                // Marker wins over a full memory: the final word was the marker.
                if (is_marker) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (wr_addr_q == LAST_ADDR) begin
                    state_d    = S_DONE;
                    done_d     = 1'b1;
                    overflow_d = 1'b1;
                end else begin
                    state_d   = S_LOAD;
                    wr_addr_d = wr_addr_q + ADDR_ONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset drops any partially assembled word at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            word_q       <= '0;
            byte_cnt_q   <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            word_count_q <= '0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            byte_cnt_q   <= byte_cnt_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            word_count_q <= word_count_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
        end
    end

    // Strobes decode straight from state, so reset clears them immediately.
    assign in_ready   = (state_q == S_LOAD);
    assign wr_en      = (state_q == S_WRITE);
    assign busy       = (state_q == S_LOAD) || (state_q == S_WRITE);
    assign done       = done_q;
    assign overflow   = overflow_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign word_count = word_count_q;

endmodule
